psram_spi_ctrl: RTL and testbench
=================================

Name: psram_spi_ctrl

Overview:
- Parametrised SPI-mode controller for the serial PSRAM on the board.
- After reset it runs the device power-up sequence: POR wait, Reset Enable 0x66, Reset 0x99.
- It then serves single read and write bursts of BURST_BYTES bytes from a valid/ready command port.
- It replaces the fixed reset/ID sequencer: command sequencing, read data capture, CE# spacing and a generated SCK are all new.

Parameters:
- BURST_BYTES, 4, data bytes per transaction (1..16).
- POR_WAIT, 15000, sys_clk cycles held idle after reset before the first command (150 us at 100 MHz).
- CEH_CYCLES, 2, minimum sys_clk cycles psram_ce_n stays high between transactions (>=1).

Ports:
- sys_clk, in, 1, system clock, max 66 MHz (SCK = sys_clk/2, 33 MHz limit of 0x03 read).
- sys_reset_n, in, 1, asynchronous active-low reset.
- init_done, out, 1, high once the power-up sequence completes; stays high until reset.
- cmd_valid, in, 1, command request.
- cmd_ready, out, 1, controller can accept a command.
- cmd_write, in, 1, 1 = write (0x02), 0 = read (0x03).
- cmd_addr, in, 24, byte address of the first byte.
- cmd_wdata, in, 8*BURST_BYTES, write data; byte 0 = bits [7:0], sent first.
- rsp_valid, out, 1, one-cycle pulse when read data is ready.
- rsp_rdata, out, 8*BURST_BYTES, read data; byte 0 = first received; held until the next read.
- id_valid, out, 1, ID fields valid.
- id_mf, out, 8, manufacturer ID.
- id_kgd, out, 8, known-good-die byte.
- psram_ce_n, out, 1, chip enable, active low, registered.
- psram_sck, out, 1, serial clock, registered, idle low.
- psram_mosi, out, 1, serial data to device (SIO0).
- psram_miso, in, 1, serial data from device (SIO1).

Behaviour:
- Reset values (asynchronous):
  - psram_ce_n=1; psram_sck=0; psram_mosi=0.
  - init_done=0; cmd_ready=0; rsp_valid=0.
  - rsp_rdata=0; id_valid=0; id_mf=0; id_kgd=0.
  - The FSM goes to POR.
- Bit timing: each bit takes 2 sys_clk cycles.
  - Phase A: sck=0, mosi holds the bit.
  - Phase B: sck=1.
  - MSB first within every byte.
  - miso is sampled on the sys_clk edge where psram_sck goes 0->1.
- CE# timing:
  - ce_n falls together with the start of phase A of the first bit.
  - ce_n rises in the cycle after phase B of the last bit; sck is 0 at that point.
  - ce_n then stays high for at least CEH_CYCLES cycles before it can fall again.
- Transaction framing:
  - Every transaction is command byte, then 24-bit address MSB first, then data.
  - Reads use no wait cycles.
- FSM states:
  - POR: counts POR_WAIT cycles.
  - RSTEN: sends 0x66.
  - GAP.
  - RST: sends 0x99.
  - GAP.
  - [RDID], under the optional feature.
  - IDLE.
  - XFER_CMD, XFER_ADDR, XFER_WR or XFER_RD.
  - CEH, then back to IDLE.
  - GAP and CEH both hold ce_n high for CEH_CYCLES.
- init_done rises on entry to IDLE after the init sequence. cmd_ready = (state==IDLE) && init_done.
- Command handshake:
  - A command is accepted on the edge where cmd_valid && cmd_ready.
  - cmd_write, cmd_addr and cmd_wdata are captured at that edge.
  - cmd_ready is 0 from the next cycle until the FSM is back in IDLE.
  - The first ce_n low is the cycle after acceptance.
- CE# low duration per transaction = 2*(32 + 8*BURST_BYTES) cycles (128 at default). Minimum accept-to-accept interval = 1 + that + CEH_CYCLES.
- Reads: rsp_rdata updates and rsp_valid pulses for exactly one cycle, in the cycle ce_n rises. Writes produce no response.
- Address wrap at the device page boundary is the device's behaviour. The controller always sends the address unmodified.
- Bursts are short, so tCEM (8 us) holds for any legal BURST_BYTES.
- cmd_valid while not ready is ignored; no queueing.
- A reset mid-transaction forces ce_n high immediately (async) and restarts from POR. No partial rsp_valid is produced.

Optional Feature:
- Macro: PSRAM_READ_ID_EN.
- Defined:
  - After the second GAP, the FSM runs RDID: 0x9F, then 24 address bits of 0, then 2 bytes captured into id_mf and id_kgd.
  - ce_n rises, then CEH, then IDLE.
  - id_valid is set with init_done.
- Undefined:
  - RDID is skipped.
  - id_mf=0 and id_kgd=0 permanently.
  - id_valid rises together with init_done.

Test Plan:
- Power-up, POR_WAIT=20: two ce_n-low windows of exactly 16 cycles each, decoding to 0x66 then 0x99, separated by >=CEH_CYCLES high cycles; init_done and cmd_ready rise after the second window.
- Write, addr 0x012345, wdata 0xDDCCBBAA (BURST_BYTES=4): MOSI decodes 02 01 23 45 AA BB CC DD; ce_n low for exactly 128 cycles; no rsp_valid.
- Read, addr 0x000010, device model returns 11 22 33 44: rsp_rdata=0x44332211; one rsp_valid pulse in the cycle ce_n rises.
- Back-to-back: cmd_valid held high with two commands: second acceptance exactly 1+128+CEH_CYCLES cycles after the first; ce_n high gap >=CEH_CYCLES.
- sys_reset_n pulsed low at bit 40 of a read: ce_n=1 and sck=0 asynchronously; no rsp_valid; full init sequence re-runs.
- PSRAM_READ_ID_EN defined, model ID 0x0D/0x5D: third init window decodes 9F 00 00 00; id_mf=0x0D, id_kgd=0x5D, id_valid=1 with init_done.

Source files
------------

// File: rtl/psram_spi_ctrl.sv
// psram_spi_ctrl
//   SPI-mode (single bit, mode 0) controller for the board serial PSRAM.
//   After reset: POR wait, Reset Enable (0x66), Reset (0x99), optional Read ID
//   (0x9F), then serves single read (0x03) / write (0x02) bursts of
//   BURST_BYTES bytes from a valid/ready command port.
//
//   Optional feature macro: PSRAM_READ_ID_EN (adds the RDID step to init and
//   drives id_mf / id_kgd from the device; otherwise they are tied to zero).
//
// Ports
//   sys_clk, sys_reset_n        clock, async active-low reset
//   init_done                   power-up sequence complete
//   cmd_valid/cmd_ready         command handshake
//   cmd_write/cmd_addr/cmd_wdata  command fields (byte 0 = bits [7:0], sent first)
//   rsp_valid/rsp_rdata         one-cycle read response, data held until next read
//   id_valid/id_mf/id_kgd       device ID fields
//   psram_ce_n/sck/mosi/miso    SPI pins (SCK = sys_clk/2, idle low)

module psram_spi_ctrl #(
  parameter int BURST_BYTES = 4,
  parameter int POR_WAIT    = 15000,
  parameter int CEH_CYCLES  = 2
) (
  input  logic                     sys_clk,
  input  logic                     sys_reset_n,
  output logic                     init_done,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_write,
  input  logic [23:0]              cmd_addr,
  input  logic [8*BURST_BYTES-1:0] cmd_wdata,
  output logic                     rsp_valid,
  output logic [8*BURST_BYTES-1:0] rsp_rdata,
  output logic                     id_valid,
  output logic [7:0]               id_mf,
  output logic [7:0]               id_kgd,
  output logic                     psram_ce_n,
  output logic                     psram_sck,
  output logic                     psram_mosi,
  input  logic                     psram_miso
);

  localparam int DW      = 8 * BURST_BYTES;
  localparam int SH_W    = 32 + DW;               // cmd + addr + data
  localparam int IN_W    = (DW > 16) ? DW : 16;   // room for the 2 ID bytes
  localparam int CNT_MAX = (POR_WAIT > CEH_CYCLES) ? POR_WAIT : CEH_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] POR_LAST  = CNT_W'(POR_WAIT - 1);
  localparam logic [CNT_W-1:0] CEH_LAST  = CNT_W'(CEH_CYCLES - 1);
  localparam logic [7:0]       DATA_LAST = 8'(DW - 1);

  localparam logic [7:0] OP_RSTEN = 8'h66;
  localparam logic [7:0] OP_RST   = 8'h99;
  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_READ  = 8'h03;
`ifdef PSRAM_READ_ID_EN
  localparam logic [7:0] OP_RDID  = 8'h9F;
`endif

  typedef enum logic [3:0] {
    S_POR, S_RSTEN, S_GAP1, S_RST, S_GAP2, S_RDID, S_IDLE,
    S_CMD, S_ADDR, S_WR, S_RD, S_CEH
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       bit_cnt;    // bits left in the current segment, minus one
  logic [SH_W-1:0]  sh_out;     // MSB is the bit on the wire
  logic [IN_W-1:0]  sh_in;
  logic             wr_q;
  logic             in_xfer;
  logic [7:0]       xfer_op;
  logic [DW-1:0]    wd_sw;

  assign cmd_ready  = (state == S_IDLE) && init_done;
  assign id_valid   = init_done;
  assign psram_mosi = sh_out[SH_W-1];
  assign in_xfer    = state inside {S_RSTEN, S_RST, S_RDID, S_CMD, S_ADDR, S_WR, S_RD};
  assign xfer_op    = cmd_write ? OP_WRITE : OP_READ;

  // Byte 0 goes out first, so it lands at the top of the shift register.
  always_comb begin
    wd_sw = '0;
    for (int i = 0; i < BURST_BYTES; i++)
      wd_sw[8*(BURST_BYTES-1-i) +: 8] = cmd_wdata[8*i +: 8];
  end

`ifndef PSRAM_READ_ID_EN
  assign id_mf  = 8'h00;
  assign id_kgd = 8'h00;
`endif

  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      state      <= S_POR;
      cnt        <= '0;
      bit_cnt    <= '0;
      sh_out     <= '0;
      sh_in      <= '0;
      wr_q       <= 1'b0;
      init_done  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      psram_ce_n <= 1'b1;
      psram_sck  <= 1'b0;
`ifdef PSRAM_READ_ID_EN
      id_mf      <= 8'h00;
      id_kgd     <= 8'h00;
`endif
    end else begin
      rsp_valid <= 1'b0;
      if (in_xfer) begin
        if (!psram_sck) begin
          // phase A -> B: this edge raises SCK, device data is valid now
          psram_sck <= 1'b1;
          sh_in     <= {sh_in[IN_W-2:0], psram_miso};
        end else if (bit_cnt != 8'd0) begin
          psram_sck <= 1'b0;
          bit_cnt   <= bit_cnt - 1'b1;
          sh_out    <= sh_out << 1;
        end else begin
          case (state)
            S_CMD: begin
              state     <= S_ADDR;
              bit_cnt   <= 8'd23;
              psram_sck <= 1'b0;
              sh_out    <= sh_out << 1;
            end
            S_ADDR: begin
              state     <= wr_q ? S_WR : S_RD;
              bit_cnt   <= DATA_LAST;
              psram_sck <= 1'b0;
              sh_out    <= sh_out << 1;
            end
            default: begin
              // last bit done: release CE# with SCK already low
              psram_sck  <= 1'b0;
              psram_ce_n <= 1'b1;
              sh_out     <= '0;
              cnt        <= '0;
              case (state)
                S_RSTEN: state <= S_GAP1;
                S_RST:   state <= S_GAP2;
                S_RD: begin
                  state     <= S_CEH;
                  rsp_valid <= 1'b1;
                  // first received byte sits highest in sh_in
                  for (int i = 0; i < BURST_BYTES; i++)
                    rsp_rdata[8*i +: 8] <= sh_in[8*(BURST_BYTES-1-i) +: 8];
                end
`ifdef PSRAM_READ_ID_EN
                S_RDID: begin
                  state  <= S_CEH;
                  id_mf  <= sh_in[15:8];
                  id_kgd <= sh_in[7:0];
                end
`endif
                default: state <= S_CEH;
              endcase
            end
          endcase
        end
      end else begin
        case (state)
          S_POR: begin
            if (cnt == POR_LAST) begin
              state      <= S_RSTEN;
              bit_cnt    <= 8'd7;
              sh_out     <= {OP_RSTEN, {(SH_W-8){1'b0}}};
              psram_ce_n <= 1'b0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_GAP1: begin
            if (cnt == CEH_LAST) begin
              state      <= S_RST;
              bit_cnt    <= 8'd7;
              sh_out     <= {OP_RST, {(SH_W-8){1'b0}}};
              psram_ce_n <= 1'b0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_GAP2: begin
            if (cnt == CEH_LAST) begin
`ifdef PSRAM_READ_ID_EN
              // 0x9F, 24 zero address bits, 2 ID bytes
              state      <= S_RDID;
              bit_cnt    <= 8'd47;
              sh_out     <= {OP_RDID, {(SH_W-8){1'b0}}};
              psram_ce_n <= 1'b0;
`else
              state      <= S_IDLE;
              init_done  <= 1'b1;
`endif
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_CEH: begin
            if (cnt == CEH_LAST) begin
              state     <= S_IDLE;
              init_done <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_IDLE: begin
            if (cmd_valid && cmd_ready) begin
              state      <= S_CMD;
              wr_q       <= cmd_write;
              bit_cnt    <= 8'd7;
              sh_out     <= {xfer_op, cmd_addr, cmd_write ? wd_sw : {DW{1'b0}}};
              psram_ce_n <= 1'b0;
              psram_sck  <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_psram_spi_ctrl.sv
// Bench for psram_spi_ctrl (BURST_BYTES=4, POR_WAIT=20, CEH_CYCLES=2).
// A behavioural PSRAM model decodes each CE# window into bits, stores
// written bytes and answers reads / RDID; expectations come from the
// command fields and a reference memory kept by the stimulus side.

module tb_psram_spi_ctrl;
  localparam int BB   = 4;
  localparam int PW   = 20;
  localparam int CH   = 2;
  localparam int TLEN = 2 * (32 + 8*BB);
`ifdef PSRAM_READ_ID_EN
  localparam int NINIT = 3;
`else
  localparam int NINIT = 2;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          init_done, cmd_valid, cmd_ready, cmd_write;
  logic [23:0]   cmd_addr;
  logic [8*BB-1:0] cmd_wdata, rsp_rdata;
  logic          rsp_valid, id_valid;
  logic [7:0]    id_mf, id_kgd;
  logic          ce_n, sck, mosi;
  logic          miso_drv = 1'b0;

  psram_spi_ctrl #(.BURST_BYTES(BB), .POR_WAIT(PW), .CEH_CYCLES(CH)) dut (
    .sys_clk(clk), .sys_reset_n(rst_n), .init_done(init_done),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .id_valid(id_valid), .id_mf(id_mf), .id_kgd(id_kgd),
    .psram_ce_n(ce_n), .psram_sck(sck), .psram_mosi(mosi), .psram_miso(miso_drv)
  );

  always #5 clk = ~clk;

  int n_tot = 0, n_bad = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- device model / bus monitor ----------------
  int          cyc = 0;
  bit          prev_ce = 1'b1, prev_sck = 1'b0;
  int          nb = 0, lo_cnt = 0, hi_cnt = 0, nwin = 0, nstart = 0;
  bit          wb [256];
  int          win_len[$], win_gap[$];
  logic [63:0] win_val[$];
  int          n_rsp = 0, n_rsp_bad = 0;
  int          acc_q[$];
  logic [7:0]  dev_mem [256];
  logic [7:0]  ref_mem [256];
  logic [15:0] id16 = 16'h0D5D;

  function automatic logic [7:0] wbyte(input int s);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[7-i] = wb[s+i];
    return b;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin : mon
    logic [63:0] v;
    logic [7:0]  b;
    int          k;
    forever begin
      @(negedge clk);
      if (!ce_n) begin
        if (prev_ce) begin
          win_gap.push_back(hi_cnt);
          nb = 0; lo_cnt = 0; nstart++;
        end
        lo_cnt++;
        if (sck && !prev_sck && nb < 256) begin
          wb[nb] = mosi;
          nb++;
        end
      end else begin
        if (!prev_ce) begin
          v = '0;
          for (int i = 0; i < nb && i < 64; i++) v = {v[62:0], wb[i]};
          win_val.push_back(v);
          win_len.push_back(lo_cnt);
          if (nb >= 32 && wbyte(0) == 8'h02)
            for (int j = 0; j < (nb-32)/8; j++)
              dev_mem[(int'(wbyte(24)) + j) % 256] = wbyte(32 + 8*j);
          nwin++;
          hi_cnt = 1;
        end else begin
          hi_cnt++;
        end
      end
      if (rsp_valid) begin
        n_rsp++;
        if (!(ce_n && !prev_ce)) n_rsp_bad++;
      end
      if (cmd_valid && cmd_ready) acc_q.push_back(cyc);
      prev_ce  = ce_n;
      prev_sck = sck;
      miso_drv = 1'b0;
      if (!ce_n && nb >= 32) begin
        k = nb - 32;
        if (wbyte(0) == 8'h03) begin
          b = dev_mem[(int'(wbyte(24)) + k/8) % 256];
          miso_drv = b[7 - (k % 8)];
        end else if (wbyte(0) == 8'h9F && k < 16) begin
          miso_drv = id16[15 - k];
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_init();
    int t = 0;
    while (!init_done && t < 2000) begin @(negedge clk); t++; end
    if (!init_done) chk("init_timeout", 0, 1);
  endtask

  task automatic wait_win(input int n);
    int t = 0;
    while (nwin < n && t < 3000) begin @(negedge clk); t++; end
    if (nwin < n) chk("win_timeout", nwin, n);
  endtask

  task automatic wait_ready();
    int t = 0;
    bit ok = 1'b0;
    while (!ok && t < 3000) begin @(negedge clk); ok = cmd_ready; t++; end
    if (!ok) chk("ready_timeout", 0, 1);
  endtask

  function automatic logic [63:0] exp_mosi(input bit wr, input logic [23:0] a,
                                           input logic [31:0] wd);
    return {wr ? 8'h02 : 8'h03, a,
            wr ? {wd[7:0], wd[15:8], wd[23:16], wd[31:24]} : 32'h0};
  endfunction

  function automatic logic [31:0] exp_rd(input logic [23:0] a);
    int  b0 = int'(a[7:0]);
    return {ref_mem[(b0+3)%256], ref_mem[(b0+2)%256], ref_mem[(b0+1)%256], ref_mem[b0]};
  endfunction

  task automatic ref_write(input logic [23:0] a, input logic [31:0] wd);
    for (int j = 0; j < BB; j++) ref_mem[(int'(a[7:0]) + j) % 256] = wd[8*j +: 8];
  endtask

  task automatic issue(input bit wr, input logic [23:0] a, input logic [31:0] wd);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = wd;
    wait_ready();
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic do_xfer(input string tag, input bit wr, input logic [23:0] a,
                         input logic [31:0] wd);
    int w0 = nwin;
    int r0 = n_rsp;
    issue(wr, a, wd);
    wait_win(w0 + 1);
    chk({tag, "_mosi"}, win_val[w0], exp_mosi(wr, a, wd));
    chk({tag, "_celen"}, win_len[w0], TLEN);
    chk({tag, "_nrsp"}, n_rsp - r0, wr ? 0 : 1);
    if (wr) ref_write(a, wd);
    else    chk({tag, "_rdata"}, rsp_rdata, exp_rd(a));
  endtask

  task automatic chk_init(input string tag, input int w0);
    chk({tag, "_nwin"}, nwin - w0, NINIT);
    chk({tag, "_w0"}, win_val[w0], 64'h66);
    chk({tag, "_l0"}, win_len[w0], 16);
    chk({tag, "_w1"}, win_val[w0+1], 64'h99);
    chk({tag, "_l1"}, win_len[w0+1], 16);
    chk({tag, "_gap"}, win_gap[w0+1] >= CH, 1);
    chk({tag, "_ready"}, cmd_ready, 1);
    chk({tag, "_idv"}, id_valid, 1);
`ifdef PSRAM_READ_ID_EN
    chk({tag, "_w2"}, win_val[w0+2], 64'h9F0000000000);
    chk({tag, "_l2"}, win_len[w0+2], 96);
    chk({tag, "_idmf"}, id_mf, 8'h0D);
    chk({tag, "_idkgd"}, id_kgd, 8'h5D);
`else
    chk({tag, "_idmf"}, id_mf, 8'h00);
    chk({tag, "_idkgd"}, id_kgd, 8'h00);
`endif
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] r, d;
    logic [23:0] a;
    int a0, w0, r0, s0, t;

    for (int i = 0; i < 256; i++) begin
      r = $urandom;
      ref_mem[i] = r[7:0];
      dev_mem[i] = r[7:0];
    end
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;

    #1 rst_n = 1'b0;
    #20;
    chk("rst_ce", ce_n, 1);
    chk("rst_sck", sck, 0);
    chk("rst_mosi", mosi, 0);
    chk("rst_init", init_done, 0);
    chk("rst_ready", cmd_ready, 0);
    chk("rst_rspv", rsp_valid, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_idv", id_valid, 0);
    chk("rst_idmf", id_mf, 0);

    @(posedge clk); #1 rst_n = 1'b1;
    wait_init();
    chk_init("pu", 0);

    // directed write then directed read
    do_xfer("wr_dir", 1'b1, 24'h012345, 32'hDDCCBBAA);
    ref_mem[16] = 8'h11; dev_mem[16] = 8'h11;
    ref_mem[17] = 8'h22; dev_mem[17] = 8'h22;
    ref_mem[18] = 8'h33; dev_mem[18] = 8'h33;
    ref_mem[19] = 8'h44; dev_mem[19] = 8'h44;
    do_xfer("rd_dir", 1'b0, 24'h000010, 32'h0);
    chk("rd_dir_val", rsp_rdata, 32'h44332211);

    // randomized reads / writes over a small address window so they overlap
    for (int i = 0; i < 16; i++) begin
      r = $urandom;
      d = $urandom;
      a = {r[23:8], 8'($urandom_range(0, 12))};
      do_xfer("rnd", r[31], a, d);
    end

    // back-to-back: cmd_valid held across two commands
    a0 = acc_q.size(); w0 = nwin; r0 = n_rsp;
    d = $urandom;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 24'hA50020; cmd_wdata = d;
    wait_ready();
    @(posedge clk); #1;
    cmd_write = 1'b0; cmd_addr = 24'h5A0020; cmd_wdata = $urandom;
    ref_write(24'hA50020, d);
    wait_ready();
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    wait_win(w0 + 2);
    chk("b2b_acc", acc_q[a0+1] - acc_q[a0], 1 + TLEN + CH);
    chk("b2b_gap", win_gap[w0+1] >= CH, 1);
    chk("b2b_mosi0", win_val[w0], exp_mosi(1'b1, 24'hA50020, d));
    chk("b2b_mosi1", win_val[w0+1], exp_mosi(1'b0, 24'h5A0020, 32'h0));
    chk("b2b_nrsp", n_rsp - r0, 1);
    chk("b2b_rdata", rsp_rdata, d);

    // reset in the middle of a read, at bit 40
    r0 = n_rsp; s0 = nstart;
    issue(1'b0, 24'h000004, 32'h0);
    t = 0;
    while (!(nstart > s0 && nb >= 40) && t < 2000) begin @(negedge clk); t++; end
    if (t >= 2000) chk("midrst_timeout", 0, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_ce", ce_n, 1);
    chk("midrst_sck", sck, 0);
    chk("midrst_init", init_done, 0);
    chk("midrst_ready", cmd_ready, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    w0 = nwin;
    wait_init();
    chk_init("reinit", w0);
    chk("midrst_nrsp", n_rsp - r0, 0);

    do_xfer("post", 1'b0, 24'h000004, 32'h0);
    chk("rsp_align", n_rsp_bad, 0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
